multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, which sets the width of instr_count.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port instr_op, input, 6 bits: opcode field from the instruction register.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-007 SHALL have these 1-bit output strobes:
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write
- ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a
REQ-008 SHALL have these 2-bit outputs: alu_src_b, alu_op, pc_source.
REQ-009 SHALL have port state, output, 4 bits: debug view of the current state encoding.
REQ-010 SHALL have port illegal_op, output, 1 bit: unsupported opcode seen in DECODE.
REQ-011 SHALL have port instr_count, output, WORD_SIZE bits: count of retired instructions.

Function
REQ-012 State encodings SHALL be:
- IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6
- EXECUTE=7, R_WB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12
- Encodings 13-15 are unused and SHALL transition to FETCH.
REQ-013 Outputs SHALL be decoded from state; any output not listed for a state SHALL be 0.
REQ-014 IDLE SHALL drive all outputs 0 and go to FETCH on the next cycle.
REQ-015 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- pc_write and ir_write SHALL equal mem_ready.
- The block SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, then branch on instr_op:
- 000000 -> EXECUTE
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 001000 -> ADDI_EX
- 000010 -> JUMP (only when the REQ-025 feature is built in)
- any other opcode -> FETCH, with illegal_op=1 for this cycle.
REQ-017 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_READ for opcode 100011 or MEM_WRITE for 101011.
REQ-018 MEM_READ SHALL drive mem_read=1, i_or_d=1; it SHALL hold until mem_ready=1, then go to MEM_WB.
- MEM_WB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1, then go to FETCH.
REQ-019 MEM_WRITE SHALL drive mem_write=1, i_or_d=1; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
- R_WB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
- The zero input is consumed by the external PC gating, not by this block.
REQ-022 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDI_WB.
- ADDI_WB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-023 instr_count SHALL increment by 1, wrapping modulo 2^WORD_SIZE, on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, ADDI_WB or JUMP.
- Illegal-opcode returns and IDLE->FETCH SHALL NOT increment it.

Reset
REQ-024 When rst=1 at a clock edge, from any state including mid-wait on mem_ready:
- state SHALL become IDLE and instr_count SHALL become 0.
- No write strobe SHALL assert in the following cycle.
- rst SHALL take priority over every transition.

Configuration
REQ-025 Macro MULTICYCLE_JUMP_EN:
- Defined: opcode 000010 SHALL go DECODE->JUMP; JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH, and is counted as retired.
- Undefined: the JUMP state SHALL be absent and 000010 SHALL be treated as illegal.

Verification
REQ-026 Reset, then R-type with mem_ready=1 -> states 0,1,2,7,8,1; reg_write=1 and reg_dst=1 only in the R_WB cycle; instr_count=1.
REQ-027 lw (100011) with mem_ready=1 -> states 1,2,3,4,5,1; mem_to_reg=1 in MEM_WB; 5 cycles per instruction.
REQ-028 sw (101011), mem_ready low for 3 cycles in MEM_WRITE -> 4 cycles with mem_write=1; reg_write never 1; instr_count increments once.
REQ-029 Opcode 111111 -> illegal_op=1 for exactly one DECODE cycle, next state FETCH, instr_count unchanged.
REQ-030 rst=1 while in MEM_READ with mem_ready=0 -> next state IDLE, all outputs 0, instr_count=0, then FETCH.
REQ-031 Opcode 000010 -> with MULTICYCLE_JUMP_EN: states 2,12,1 with pc_write=1, pc_source=10; without it: illegal_op=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a Moore-style state machine that
// sequences fetch, decode, memory, ALU and write-back steps, and counts
// retired instructions.
// Optional jump support is built in when MULTICYCLE_JUMP_EN is defined;
// without it opcode 000010 is reported as illegal.
module multicycle_control #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           instr_op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [WORD_SIZE-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

`ifdef MULTICYCLE_JUMP_EN
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 retire;

  // The zero flag gates the PC externally; it is not used inside this block.
  logic zero_unused;
  assign zero_unused = zero;

  // Next-state and control decode from the current state.
  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 is computed while the instruction word is read; PC and IR
        // only update in the cycle memory actually delivers the word.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed speculatively during decode.
        alu_src_b = 2'b11;
        case (instr_op)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (instr_op == OP_LW)      state_d = S_MEM_READ;
        else if (instr_op == OP_SW) state_d = S_MEM_WRITE;
        else                        state_d = S_FETCH;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
`endif
      // Unused encodings recover by restarting a fetch, without retiring.
      default: state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter wraps naturally at 2^WORD_SIZE.
  always_comb begin
    count_d = count_q;
    if (retire) count_d = count_q + WORD_SIZE'(1);
  end

  // State and counter registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control, plus a hand-written
// mid-wait reset sequence. A second instance with a 2-bit counter checks
// counter wrap-around.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instr_op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  logic        w_pc_write_unused, w_pc_write_cond_unused, w_i_or_d_unused;
  logic        w_mem_read_unused, w_mem_write_unused, w_ir_write_unused;
  logic        w_mem_to_reg_unused, w_reg_dst_unused, w_reg_write_unused;
  logic        w_alu_src_a_unused, w_illegal_unused;
  logic [1:0]  w_alu_src_b_unused, w_alu_op_unused, w_pc_source_unused;
  logic [3:0]  w_state_unused;
  logic [1:0]  w_count;

  always #5 clk = ~clk;

  multicycle_control #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  multicycle_control #(.WORD_SIZE(2)) dut_w2 (
    .clk(clk), .rst(rst), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w_pc_write_unused), .pc_write_cond(w_pc_write_cond_unused),
    .i_or_d(w_i_or_d_unused), .mem_read(w_mem_read_unused),
    .mem_write(w_mem_write_unused), .ir_write(w_ir_write_unused),
    .mem_to_reg(w_mem_to_reg_unused), .reg_dst(w_reg_dst_unused),
    .reg_write(w_reg_write_unused), .alu_src_a(w_alu_src_a_unused),
    .alu_src_b(w_alu_src_b_unused), .alu_op(w_alu_op_unused),
    .pc_source(w_pc_source_unused), .state(w_state_unused),
    .illegal_op(w_illegal_unused), .instr_count(w_count)
  );

  // Packed control word:
  // [15]pc_write [14]pc_write_cond [13]i_or_d [12]mem_read [11]mem_write
  // [10]ir_write [9]mem_to_reg [8]reg_dst [7]reg_write [6]alu_src_a
  // [5:4]alu_src_b [3:2]alu_op [1:0]pc_source
  logic [15:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [15:0] C_IDLE     = 16'h0000;
  localparam logic [15:0] C_FETCH_W  = 16'h1010;
  localparam logic [15:0] C_FETCH_G  = 16'h9410;
  localparam logic [15:0] C_DECODE   = 16'h0030;
  localparam logic [15:0] C_MEMADDR  = 16'h0060;
  localparam logic [15:0] C_MEMREAD  = 16'h3000;
  localparam logic [15:0] C_MEMWB    = 16'h0280;
  localparam logic [15:0] C_MEMWRITE = 16'h2800;
  localparam logic [15:0] C_EXEC     = 16'h0048;
  localparam logic [15:0] C_RWB      = 16'h0180;
  localparam logic [15:0] C_BRANCH   = 16'h4045;
  localparam logic [15:0] C_ADDIEX   = 16'h0060;
  localparam logic [15:0] C_ADDIWB   = 16'h0080;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [15:0] C_JUMP     = 16'h8002;
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [15:0] c,
                     input logic ill, input int unsigned cnt);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle to the
  // falling edge where outputs are sampled.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; instr_op = op; mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    rst = 1'b1; instr_op = 6'd0; zero = 1'b0; mem_ready = 1'b0;

    // Each vector: inputs for this cycle, expected state/outputs/count before the next edge.
    add(0, 6'o00, 1, 4'd0,  C_IDLE,     0, 0);  // reset state
    // R-type
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 0);
    add(0, 6'b000000, 0, 4'd2, C_DECODE, 0, 0);
    add(0, 6'o00, 0, 4'd7,  C_EXEC,     0, 0);
    add(0, 6'o00, 0, 4'd8,  C_RWB,      0, 0);
    // lw, with mem_ready already high
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 1);
    add(0, 6'b100011, 0, 4'd2, C_DECODE, 0, 1);
    add(0, 6'b100011, 1, 4'd3, C_MEMADDR, 0, 1);
    add(0, 6'o00, 1, 4'd4,  C_MEMREAD,  0, 1);
    add(0, 6'o00, 0, 4'd5,  C_MEMWB,    0, 1);
    // fetch stall for one cycle
    add(0, 6'o00, 0, 4'd1,  C_FETCH_W,  0, 2);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 2);
    // sw with three wait cycles
    add(0, 6'b101011, 0, 4'd2, C_DECODE, 0, 2);
    add(0, 6'b101011, 0, 4'd3, C_MEMADDR, 0, 2);
    add(0, 6'o00, 0, 4'd6,  C_MEMWRITE, 0, 2);
    add(0, 6'o00, 0, 4'd6,  C_MEMWRITE, 0, 2);
    add(0, 6'o00, 0, 4'd6,  C_MEMWRITE, 0, 2);
    add(0, 6'o00, 1, 4'd6,  C_MEMWRITE, 0, 2);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 3);
    // beq
    add(0, 6'b000100, 0, 4'd2, C_DECODE, 0, 3);
    add(0, 6'o00, 0, 4'd9,  C_BRANCH,   0, 3);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 4);
    // addi
    add(0, 6'b001000, 0, 4'd2, C_DECODE, 0, 4);
    add(0, 6'o00, 0, 4'd10, C_ADDIEX,   0, 4);
    add(0, 6'o00, 0, 4'd11, C_ADDIWB,   0, 4);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 5);
    // illegal opcode: one DECODE cycle flagged, count unchanged
    add(0, 6'b111111, 0, 4'd2, C_DECODE, 1, 5);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 5);
`ifdef MULTICYCLE_JUMP_EN
    add(0, 6'b000010, 0, 4'd2, C_DECODE, 0, 5);
    add(0, 6'o00, 0, 4'd12, C_JUMP,     0, 5);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 6);
`else
    add(0, 6'b000010, 0, 4'd2, C_DECODE, 1, 5);
    add(0, 6'o00, 1, 4'd1,  C_FETCH_G,  0, 5);
`endif

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      chk($sformatf("v%0d state", i), state, vecs[i].st);
      chk($sformatf("v%0d ctl", i), ctl, vecs[i].ctl);
      chk($sformatf("v%0d illegal_op", i), illegal_op, vecs[i].ill);
      chk($sformatf("v%0d instr_count", i), instr_count, vecs[i].cnt);
      chk($sformatf("v%0d count_w2", i), w_count, vecs[i].cnt % 4);
    end

    // Reset while MEM_READ is waiting on memory.
    step(0, 6'b100011, 0);
    chk("rs decode", state, 4'd2);
    step(0, 6'b100011, 0);
    chk("rs mem_addr", state, 4'd3);
    step(0, 6'o00, 0);
    chk("rs mem_read", state, 4'd4);
    step(1, 6'o00, 0);
    chk("rs mem_read hold", state, 4'd4);
    chk("rs mem_read ctl", ctl, C_MEMREAD);
    step(0, 6'o00, 0);
    chk("rs idle state", state, 4'd0);
    chk("rs idle ctl", ctl, C_IDLE);
    chk("rs idle illegal", illegal_op, 1'b0);
    chk("rs idle count", instr_count, 0);
    chk("rs idle count_w2", w_count, 0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      step(0, 6'o00, 0);
      if (state == 4'd1) found = 1'b1;
    end
    chk("rs reach fetch", found, 1'b1);
    chk("rs fetch ctl", ctl, C_FETCH_W);
    chk("rs fetch count", instr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
